// File: rtl/mpu_temp_avg_filter.sv
// mpu_temp_avg_filter: boxcar average over the last 2^LOG2_DEPTH raw temperature samples,
// plus signed min/max tracking since reset/clear.
module mpu_temp_avg_filter #(
  parameter int LOG2_DEPTH = 3
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        i_sample_valid,
  input  logic [15:0] i_sample,
  input  logic        i_clear,
  output logic [15:0] o_avg,
  output logic        o_avg_valid,
  output logic        o_filled,
  output logic [15:0] o_min,
  output logic [15:0] o_max
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW = 16 + LOG2_DEPTH;
  logic [15:0] buf_q [DEPTH];
  logic signed [SW-1:0] sum_q, sum_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH:0] count_q, count_d;
  logic [15:0] min_q, min_d, max_q, max_d, avg_q, avg_d;
  logic pend_q, avg_valid_q, accept, first;
  assign accept = i_sample_valid & ~i_clear;
  assign o_filled = count_q == (LOG2_DEPTH+1)'(DEPTH);
  assign first = count_q == '0;
  always_comb begin
    sum_d = sum_q + SW'(signed'(i_sample)) - SW'(signed'(buf_q[wr_ptr_q]));
    count_d = o_filled ? count_q : count_q + 1'b1;
    min_d = (first || $signed(i_sample) < $signed(min_q)) ? i_sample : min_q;
    max_d = (first || $signed(i_sample) > $signed(max_q)) ? i_sample : max_q;
    // Arithmetic shift floors toward -inf; the quotient always fits in 16 bits.
    avg_d = pend_q ? 16'(sum_q >>> LOG2_DEPTH) : avg_q;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      min_q <= '0;
      max_q <= '0;
      avg_q <= '0;
      pend_q <= 1'b0;
      avg_valid_q <= 1'b0;
    end else if (i_clear) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      sum_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      min_q <= '0;
      max_q <= '0;
      pend_q <= 1'b0;
      avg_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        buf_q[wr_ptr_q] <= i_sample;
        sum_q <= sum_d;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        count_q <= count_d;
        min_q <= min_d;
        max_q <= max_d;
      end
      pend_q <= accept;
      avg_valid_q <= pend_q;
      avg_q <= avg_d;
    end
  end
  assign o_avg = avg_q;
  assign o_avg_valid = avg_valid_q;
  assign o_min = min_q;
  assign o_max = max_q;
endmodule

// File: tb/tb_mpu_temp_avg_filter.sv
// tb_mpu_temp_avg_filter: directed + random stimulus against a queue-based window model.
module tb_mpu_temp_avg_filter;
  localparam int L = 3;
  localparam int DEPTH = 1 << L;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, clr = 1'b0;
  logic [15:0] sample = '0;
  logic [15:0] avg, mn, mx;
  logic avg_valid, filled;
  int n_tests = 0, n_fail = 0;
  int hist[$];
  int n_acc, e_min, e_max, e_avg, p_avg, n_vld;
  bit pend, e_vld;

  mpu_temp_avg_filter #(.LOG2_DEPTH(L)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_sample_valid(valid), .i_sample(sample), .i_clear(clr),
    .o_avg(avg), .o_avg_valid(avg_valid), .o_filled(filled), .o_min(mn), .o_max(mx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int fdiv(input int s);
    return (s - (((s % DEPTH) + DEPTH) % DEPTH)) / DEPTH;
  endfunction

  function automatic void model_reset();
    hist.delete();
    n_acc = 0; e_min = 0; e_max = 0; e_avg = 0; p_avg = 0; pend = 0; e_vld = 0;
  endfunction

  function automatic void model_edge(input bit v, input int s, input bit c);
    int sum;
    e_vld = pend && !c;
    if (e_vld) e_avg = p_avg;
    if (c) begin
      hist.delete();
      n_acc = 0; e_min = 0; e_max = 0; pend = 0;
    end else begin
      pend = v;
      if (v) begin
        hist.push_back(s);
        if (hist.size() > DEPTH) void'(hist.pop_front());
        e_min = (n_acc == 0 || s < e_min) ? s : e_min;
        e_max = (n_acc == 0 || s > e_max) ? s : e_max;
        n_acc++;
        sum = 0;
        foreach (hist[i]) sum += hist[i];
        p_avg = fdiv(sum);
      end
    end
  endfunction

  task automatic check_outputs();
    chk("avg_valid", 16'(avg_valid), 16'(e_vld));
    chk("avg", avg, 16'(e_avg));
    chk("filled", 16'(filled), 16'(n_acc >= DEPTH));
    chk("min", mn, 16'(e_min));
    chk("max", mx, 16'(e_max));
    if (avg_valid) n_vld++;
  endtask

  task automatic cycle(input bit v, input logic [15:0] s, input bit c);
    valid = v; sample = s; clr = c;
    @(posedge clk);
    model_edge(v, int'($signed(s)), c);
    @(negedge clk);
    valid = 0; clr = 0;
    check_outputs();
  endtask

  task automatic strobe_spaced(input logic [15:0] s, input int gap);
    cycle(1, s, 0);
    repeat (gap - 1) cycle(0, 16'h0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_reset();
    chk("rst_avg", avg, 16'h0);
    chk("rst_valid", 16'(avg_valid), 16'h0);
    chk("rst_filled", 16'(filled), 16'h0);
    chk("rst_min", mn, 16'h0);
    chk("rst_max", mx, 16'h0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    // constant fill and window slide
    for (int i = 0; i < 8; i++) strobe_spaced(16'h0100, 5);
    chk("fill_avg", avg, 16'h0100);
    chk("fill_filled", 16'(filled), 16'h1);
    for (int i = 0; i < 8; i++) strobe_spaced(16'h0200, 5);
    chk("slide_avg", avg, 16'h0200);
    // negative / floor
    do_reset();
    for (int i = 0; i < 8; i++) strobe_spaced(16'hFFFF, 3);
    chk("neg_avg", avg, 16'hFFFF);
    do_reset();
    strobe_spaced(16'hFFF9, 3);
    chk("floor_avg", avg, 16'hFFFF);
    strobe_spaced(16'h7FFF, 3);
    strobe_spaced(16'h8000, 3);
    chk("ext_max", mx, 16'h7FFF);
    chk("ext_min", mn, 16'h8000);
    // back-to-back ramp
    do_reset();
    n_vld = 0;
    for (int i = 0; i < 16; i++) cycle(1, 16'(i), 0);
    repeat (3) cycle(0, 16'h0, 0);
    chk("b2b_count", 16'(n_vld), 16'd16);
    chk("b2b_avg", avg, 16'h000B);
    // clear collision
    for (int i = 0; i < 5; i++) cycle(1, 16'(100 + i), 0);
    cycle(1, 16'h1234, 1);
    n_vld = 0;
    repeat (3) cycle(0, 16'h0, 0);
    chk("clr_novalid", 16'(n_vld), 16'd0);
    chk("clr_min", mn, 16'h0);
    strobe_spaced(16'h0040, 3);
    chk("clr_next_avg", avg, 16'h0008);
    // async reset between strobe and its valid
    valid = 1; sample = 16'h0555;
    @(posedge clk);
    model_edge(1, 16'h0555, 0);
    valid = 0;
    #2;
    do_reset();
    n_vld = 0;
    repeat (4) cycle(0, 16'h0, 0);
    chk("arst_novalid", 16'(n_vld), 16'd0);
    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] s;
      int r = $urandom_range(0, 9);
      s = r == 0 ? 16'h7FFF : r == 1 ? 16'h8000 : 16'($urandom);
      cycle($urandom_range(0, 1), s, $urandom_range(0, 39) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
